// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock, 2*SIZE-bit product.
// Optional early termination when the remaining multiplier bits are zero: SHIFT_ADD_MULT_EARLY_EXIT_EN.
module shift_add_multiplier #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIZE-1:0]   multiplicand,
    input  logic [SIZE-1:0]   multiplier,
    output logic [2*SIZE-1:0] product,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    localparam int CW = $clog2(SIZE) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2*SIZE-1:0] acc_q, acc_d;
    logic [2*SIZE-1:0] mcand_q, mcand_d;
    logic [SIZE-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*SIZE-1:0] product_q, product_d;
    logic [2*SIZE-1:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // The shifted multiplicand never exceeds 2*SIZE bits, so the sum cannot overflow.
    assign sum = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mcand_d = {{SIZE{1'b0}}, multiplicand};
                    mplr_d  = multiplier;
                    cnt_d   = CW'(SIZE);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
                if (mplr_q == '0) begin
                    product_d = acc_q;
                    state_d   = S_DONE;
                end else begin
                    acc_d   = sum;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        product_d = sum;
                        state_d   = S_DONE;
                    end
                end
`else
                acc_d   = sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = sum;
                    state_d   = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign product     = product_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed, table-driven bench for shift_add_multiplier (SIZE=32), covering latency, busy/done
// shape, start-while-busy, and asynchronous reset mid-calculation.
module tb_shift_add_multiplier;

    localparam int SIZE = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SIZE-1:0]   multiplicand;
    logic [SIZE-1:0]   multiplier;
    logic [2*SIZE-1:0] product;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    shift_add_multiplier #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        logic [2*SIZE-1:0] p;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [SIZE-1:0] b);
        int l;
        l = SIZE;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        if (b == '0) l = 1;
        else begin
            for (int i = 0; i < SIZE; i++)
                if (b[i]) l = (i + 2 < SIZE) ? i + 2 : SIZE;
        end
`else
        if (b === 'x) l = SIZE;
`endif
        return l;
    endfunction

    // Accept one operation from IDLE and follow it to completion.
    task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [2*SIZE-1:0] exp, input string tag);
        int lat, busy_n, el;
        bit seen;
        el = exp_lat(b);
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk);
        #1;
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
        lat = 0; busy_n = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk({tag, " seen_done"}, 64'(seen), 64'd1);
        chk({tag, " product"}, product, exp);
        chk({tag, " latency"}, 64'(lat), 64'(el));
        chk({tag, " busy_cycles"}, 64'(busy_n), 64'(el + 1));
        @(negedge clk);
        chk({tag, " done_pulse_end"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat1, acc2, e2, dcnt, k;
        int d1_k, d2_k;
        logic [2*SIZE-1:0] d1_p, d2_p, p_mid, exp2;
        logic [SIZE-1:0] a2, b2;

        vecs[0]  = '{32'd7,          32'd6,          64'd42};
        vecs[1]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[2]  = '{32'h12345678,   32'd0,          64'd0};
        vecs[3]  = '{32'd0,          32'hDEADBEEF,   64'd0};
        vecs[4]  = '{32'd3,          32'd5,          64'd15};
        vecs[5]  = '{32'd1,          32'd1,          64'd1};
        vecs[6]  = '{32'h80000000,   32'd2,          64'h100000000};
        vecs[7]  = '{32'hFFFFFFFF,   32'd1,          64'hFFFFFFFF};
        vecs[8]  = '{32'h00010000,   32'h00010000,   64'h100000000};
        vecs[9]  = '{32'd12345,      32'd6789,       64'd83810205};
        vecs[10] = '{32'h80000000,   32'h80000000,   64'h4000000000000000};
        vecs[11] = '{32'hDEADBEEF,   32'd2,          64'h1BD5B7DDE};

        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        #2;
        chk("reset product", product, 64'd0);
        chk("reset busy_done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // start held high with operands changing every cycle; only IDLE accepts count.
        lat1 = exp_lat(32'd3);
        acc2 = lat1 + 2;
        a2   = SIZE'(acc2 + 2);
        b2   = SIZE'(acc2 + 3);
        exp2 = 64'(a2) * 64'(b2);
        e2   = acc2 + exp_lat(b2);
        dcnt = 0; d1_k = -1; d2_k = -1; d1_p = '0; d2_p = '0; p_mid = '0;
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd3;
        for (k = 0; k <= e2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin d1_k = k; d1_p = product; end
                if (dcnt == 2) begin d2_k = k; d2_p = product; end
            end
            if (k == e2 - 1) p_mid = product;
            multiplicand = SIZE'(k + 3);
            multiplier   = SIZE'(k + 4);
        end
        start = 1'b0;
        chk("held done_count", 64'(dcnt), 64'd2);
        chk("held first_done_cycle", 64'(d1_k), 64'(lat1));
        chk("held first_product", d1_p, 64'd6);
        chk("held product_stable_in_calc", p_mid, 64'd6);
        chk("held second_done_cycle", 64'(d2_k), 64'(e2));
        chk("held second_product", d2_p, exp2);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd9; multiplier = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_reset busy", 64'(busy), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset product", product, 64'd0);
        chk("async_reset busy", 64'(busy), 64'd0);
        chk("async_reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd3, 32'd5, 64'd15, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
